// File: rtl/group_gp_stage.sv
// group_gp_stage
//   Front stage of the parallel-prefix adder. Each accepted operand beat is
//   reduced to per-bit propagate/generate and then to one (G,P) pair per
//   GROUPSIZE-bit group. The result is registered into a 2-entry skid FIFO
//   that feeds the second-level prefix tree. Bitwise p/g and the effective
//   carry-in are forwarded with each beat for the downstream sum stage.
//
//   Optional build macro: GROUP_GP_SUB_EN
//     When defined, a 'sub' input is added. With sub=1 the stage computes
//     a + ~b + 1 (b' = ~b, cin' = 1). With sub=0, or without the macro,
//     b' = b and cin' = cin.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   in_valid/in_ready: operand handshake (in_ready depends on registered state only)
//   a, b, cin        : operands and carry-in (sub when GROUP_GP_SUB_EN)
//   out_valid/out_ready : result handshake
//   gp_o             : group pairs, gp_o[2k+1]=G_k, gp_o[2k]=P_k
//   p_o, g_o         : bitwise propagate/generate of a and b'
//   cin_o            : effective carry-in cin'
module group_gp_stage #(
  parameter int INPUTSIZE = 64,
  parameter int GROUPSIZE = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [INPUTSIZE-1:0]              a,
  input  logic [INPUTSIZE-1:0]              b,
  input  logic                              cin,
`ifdef GROUP_GP_SUB_EN
  input  logic                              sub,
`endif
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [2*(INPUTSIZE/GROUPSIZE)-1:0] gp_o,
  output logic [INPUTSIZE-1:0]              p_o,
  output logic [INPUTSIZE-1:0]              g_o,
  output logic                              cin_o
);

  localparam int NGROUP = INPUTSIZE / GROUPSIZE;
  // Packed entry layout: {gp, p, g, cin}
  localparam int EW = 2*NGROUP + 2*INPUTSIZE + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // ---------------------------------------------------------------
  // Effective operands
  // ---------------------------------------------------------------
  logic [INPUTSIZE-1:0] b_eff;
  logic                 cin_eff;

`ifdef GROUP_GP_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  logic [INPUTSIZE-1:0] p_bit;
  logic [INPUTSIZE-1:0] g_bit;

  assign p_bit = a ^ b_eff;
  assign g_bit = a & b_eff;

  // ---------------------------------------------------------------
  // Group reduction
  // ---------------------------------------------------------------
  logic [2*NGROUP-1:0] gp_comb;

  generate
    for (genvar gi = 0; gi < NGROUP; gi++) begin : g_group
      logic [GROUPSIZE-1:0] p_grp;
      logic [GROUPSIZE-1:0] g_grp;
      logic                 grp_g;
      logic                 grp_p;

      assign p_grp = p_bit[gi*GROUPSIZE +: GROUPSIZE];
      assign g_grp = g_bit[gi*GROUPSIZE +: GROUPSIZE];

      // Folding from the LSB upward yields the lookahead form
      // OR_j g[j] & p[j+1..top] once the top bit has been absorbed.
      always_comb begin
        grp_g = 1'b0;
        for (int j = 0; j < GROUPSIZE; j++) begin
          grp_g = g_grp[j] | (p_grp[j] & grp_g);
        end
      end

      assign grp_p = &p_grp;

      if (gi == 0) begin : g_cin
        // Carry-in is absorbed into group 0 so the tree sees no separate cin.
        assign gp_comb[1] = grp_g | (grp_p & cin_eff);
      end else begin : g_nocin
        assign gp_comb[2*gi+1] = grp_g;
      end
      assign gp_comb[2*gi] = grp_p;
    end
  endgenerate

  // ---------------------------------------------------------------
  // 2-entry skid FIFO
  // ---------------------------------------------------------------
  state_e          state_q, state_d;
  logic            head_q, tail_q;
  logic [EW-1:0]   mem_q [2];
  logic            push, pop;
  logic [EW-1:0]   head_entry;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (!push && pop) state_d = EMPTY;
      end
      FULL:  if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        mem_q[tail_q] <= {gp_comb, p_bit, g_bit, cin_eff};
        tail_q        <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
    end
  end

  assign head_entry = mem_q[head_q];
  assign gp_o  = head_entry[EW-1 -: 2*NGROUP];
  assign p_o   = head_entry[2*INPUTSIZE : INPUTSIZE+1];
  assign g_o   = head_entry[INPUTSIZE : 1];
  assign cin_o = head_entry[0];

endmodule

// File: tb/tb_group_gp_stage.sv
module tb_group_gp_stage;

  localparam int W  = 64;
  localparam int NG = 16;

  typedef struct packed {
    logic [2*NG-1:0] gp;
    logic [W-1:0]    p;
    logic [W-1:0]    g;
    logic            cin;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [2*NG-1:0] gp_o;
  logic [W-1:0]  p_o;
  logic [W-1:0]  g_o;
  logic          cin_o;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  group_gp_stage #(.INPUTSIZE(W), .GROUPSIZE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef GROUP_GP_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gp_o      (gp_o),
    .p_o       (p_o),
    .g_o       (g_o),
    .cin_o     (cin_o)
  );

  // Reference: G_k is the carry out of the 4-bit sum of the group
  // (with cin' added into group 0), P_k is the AND of the group's p bits.
  function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic cc, input logic ss);
    exp_t e;
    logic [W-1:0] be;
    logic         ce;
    logic [4:0]   s;
    logic [3:0]   pg;
    be = ss ? ~bb : bb;
    ce = ss ? 1'b1 : cc;
    e.p   = aa ^ be;
    e.g   = aa & be;
    e.cin = ce;
    for (int k = 0; k < NG; k++) begin
      s  = {1'b0, aa[k*4 +: 4]} + {1'b0, be[k*4 +: 4]} + ((k == 0) ? {4'd0, ce} : 5'd0);
      pg = e.p[k*4 +: 4];
      e.gp[2*k+1] = s[4];
      e.gp[2*k]   = &pg;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every beat the DUT hands off is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      pops++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual gp=%0h required=no beat", gp_o);
      end else begin
        e = sb.pop_front();
        check("beat_gp",  64'(gp_o),  64'(e.gp));
        check("beat_p",   p_o,        e.p);
        check("beat_g",   g_o,        e.g);
        check("beat_cin", 64'(cin_o), 64'(e.cin));
        $display("beat %0d gp=%08h p=%016h g=%016h cin=%0b", pops, gp_o, p_o, g_o, cin_o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   p0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    tick; tick;
    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_gp",        64'(gp_o),      64'd0);
    check("rst_p",         p_o,            64'd0);
    check("rst_g",         g_o,            64'd0);
    check("rst_cin",       64'(cin_o),     64'd0);
    rst = 1'b0;

    // Basic beat, hand-computed values
    out_ready = 1'b1;
    in_valid = 1'b1; a = 64'h0F; b = 64'h01; cin = 1'b0;
    e.gp = 32'h0000_0002; e.p = 64'h0E; e.g = 64'h01; e.cin = 1'b0; sb.push_back(e);
    tick;
    in_valid = 1'b0;
    check("latency_out_valid", 64'(out_valid), 64'd1);
    tick;

    // All-ones + 0, without and with carry-in
    in_valid = 1'b1; a = '1; b = '0; cin = 1'b0;
    e.gp = 32'h5555_5555; e.p = '1; e.g = '0; e.cin = 1'b0; sb.push_back(e);
    tick;
    cin = 1'b1;
    e.gp = 32'h5555_5557; e.p = '1; e.g = '0; e.cin = 1'b1; sb.push_back(e);
    tick;
    in_valid = 1'b0;
    tick;
    check("drained_out_valid", 64'(out_valid), 64'd0);

    // Backpressure: third beat must be refused
    out_ready = 1'b0;
    in_valid = 1'b1; a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; cin = 1'b0;
    sb.push_back(model(a, b, cin, 1'b0));
    tick;
    check("bp_ready_after_1", 64'(in_ready), 64'd1);
    a = 64'hFFFF_0000_FFFF_0000; b = 64'h0001_FFFF_0001_FFFF; cin = 1'b1;
    sb.push_back(model(a, b, cin, 1'b0));
    tick;
    check("bp_ready_after_2", 64'(in_ready), 64'd0);
    a = 64'hDEAD_BEEF_DEAD_BEEF; b = 64'h1111_1111_1111_1111; cin = 1'b0;
    tick;
    check("bp_ready_held", 64'(in_ready),  64'd0);
    check("bp_valid_held", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    check("bp_ready_after_pop", 64'(in_ready), 64'd1);
    tick;
    check("bp_drained", 64'(out_valid), 64'd0);

    // Streaming: one beat per cycle, occupancy stays at one
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; a = 64'(i + 1) * 64'h0123_4567_89AB_CDEF; b = 64'hF0F0_F0F0_0F0F_0F0F; cin = i[0];
      sb.push_back(model(a, b, cin, 1'b0));
      tick;
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_ready", 64'(in_ready),  64'd1);
    end
    in_valid = 1'b0;
    tick;
    check("stream_pops", 64'(pops - p0), 64'd8);

`ifdef GROUP_GP_SUB_EN
    in_valid = 1'b1; a = 64'd5; b = 64'd5; cin = 1'b0; sub = 1'b1;
    e.gp = 32'h5555_5557; e.p = '1; e.g = '0; e.cin = 1'b1; sb.push_back(e);
    tick;
    in_valid = 1'b0; sub = 1'b0;
    tick;
`endif

    // Reset while FULL: contents discarded
    out_ready = 1'b0;
    in_valid = 1'b1; a = 64'hAAAA; b = 64'h5555; cin = 1'b1;
    tick; tick;
    check("full_before_rst", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready",  64'(in_ready),  64'd1);
    check("mid_rst_gp",        64'(gp_o),      64'd0);
    check("mid_rst_p",         p_o,            64'd0);
    check("mid_rst_g",         g_o,            64'd0);
    check("mid_rst_cin",       64'(cin_o),     64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("no_stale_valid", 64'(out_valid), 64'd0);
    end

    // Scoreboard must be empty (bounded wait)
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick;
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
